// File: rtl/reg_file_dump.sv
// Sequential debug reader for the register file: walks FIRST_REG..NUM_REGS-1 through
// one read port and streams each {address, data} pair out over a valid/ready interface.
module reg_file_dump #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   idx_reg, idx_next;
  logic                valid_reg, valid_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                last_reg, last_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= FIRST_IDX;
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          idx_next   = FIRST_IDX;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          data_next  = rd_data;
          addr_next  = idx_reg;
          last_next  = (idx_reg == LAST_IDX);
          valid_next = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        // abort wins over a simultaneous handshake: the word is dropped
        if (abort) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end else if (out_ready) begin
          valid_next = 1'b0;
          if (last_reg) begin
            last_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = FETCH;
          end
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // busy is registered, so it follows the state being entered
  assign busy_next = (state_next != IDLE);

  assign rd_addr   = (state_reg == FETCH) ? idx_reg : '0;
  assign out_valid = valid_reg;
  assign out_addr  = addr_reg;
  assign out_data  = data_reg;
  assign out_last  = last_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
